// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder; slave = encoder, master = requester/consumer.
`ifndef INSTR_ENCODER_DEFS_SV
`include "instr_encoder_defs.sv"
`endif

interface instr_encoder_if;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [`INST_ID_LEN-1:0] instr_id_i;
  logic [4:0]              rd_i;
  logic [4:0]              rs1_i;
  logic [4:0]              rs2_i;
  logic [31:0]             imm_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [31:0]             instr_o;
  logic                    err_o;
  logic [15:0]             err_cnt_o;

  modport slave (
    input  in_valid_i, instr_id_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );

  modport master (
    output in_valid_i, instr_id_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/instr_encoder_defs.sv
// Shared instruction-ID width and internal ID codes used by the encoder and its users.
`ifndef INSTR_ENCODER_DEFS_SV
`define INSTR_ENCODER_DEFS_SV

`define INST_ID_LEN 6

`define NONE_ID  6'd0
`define LUI_ID   6'd1
`define AUIPC_ID 6'd2
`define ADDI_ID  6'd3
`define SLTI_ID  6'd4
`define SLTIU_ID 6'd5
`define XORI_ID  6'd6
`define ORI_ID   6'd7
`define ANDI_ID  6'd8
`define SLLI_ID  6'd9
`define SRLI_ID  6'd10
`define SRAI_ID  6'd11
`define ADD_ID   6'd12
`define SUB_ID   6'd13
`define SLL_ID   6'd14
`define SLT_ID   6'd15
`define SLTU_ID  6'd16
`define XOR_ID   6'd17
`define SRL_ID   6'd18
`define SRA_ID   6'd19
`define OR_ID    6'd20
`define AND_ID   6'd21
`define LB_ID    6'd22
`define LH_ID    6'd23
`define LW_ID    6'd24
`define LBU_ID   6'd25
`define LHU_ID   6'd26
`define SB_ID    6'd27
`define SH_ID    6'd28
`define SW_ID    6'd29

`endif

// File: rtl/instr_encoder.sv
// Pipelined RV32I instruction encoder feeding a 2-entry output FIFO.
// Define INSTR_ENC_ERR_CNT_EN to enable the saturating illegal-ID counter on err_cnt_o.
`ifndef INSTR_ENCODER_DEFS_SV
`include "instr_encoder_defs.sv"
`endif

module instr_encoder (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_encoder_if.slave enc
);

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_SH,
    FMT_R,
    FMT_U,
    FMT_S
  } fmt_e;

  opcode_e     opc;
  fmt_e        fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic [31:0] word;

  logic        accept, push, pop;
  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  always_comb begin
    legal = 1'b1;
    opc   = OPC_OP_IMM;
    fmt   = FMT_I;
    f3    = 3'd0;
    f7    = 7'd0;
    case (enc.instr_id_i)
      `ADDI_ID:  f3 = 3'd0;
      `SLTI_ID:  f3 = 3'd2;
      `SLTIU_ID: f3 = 3'd3;
      `XORI_ID:  f3 = 3'd4;
      `ORI_ID:   f3 = 3'd6;
      `ANDI_ID:  f3 = 3'd7;
      `SLLI_ID:  begin fmt = FMT_SH; f3 = 3'd1; end
      `SRLI_ID:  begin fmt = FMT_SH; f3 = 3'd5; end
      `SRAI_ID:  begin fmt = FMT_SH; f3 = 3'd5; f7 = 7'b0100000; end
      `ADD_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd0; end
      `SUB_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd0; f7 = 7'b0100000; end
      `SLL_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd1; end
      `SLT_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd2; end
      `SLTU_ID:  begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd3; end
      `XOR_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd4; end
      `SRL_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd5; end
      `SRA_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd5; f7 = 7'b0100000; end
      `OR_ID:    begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd6; end
      `AND_ID:   begin opc = OPC_OP; fmt = FMT_R; f3 = 3'd7; end
      `LUI_ID:   begin opc = OPC_LUI;   fmt = FMT_U; end
      `AUIPC_ID: begin opc = OPC_AUIPC; fmt = FMT_U; end
      `LB_ID:    begin opc = OPC_LOAD; f3 = 3'd0; end
      `LH_ID:    begin opc = OPC_LOAD; f3 = 3'd1; end
      `LW_ID:    begin opc = OPC_LOAD; f3 = 3'd2; end
      `LBU_ID:   begin opc = OPC_LOAD; f3 = 3'd4; end
      `LHU_ID:   begin opc = OPC_LOAD; f3 = 3'd5; end
      `SB_ID:    begin opc = OPC_STORE; fmt = FMT_S; f3 = 3'd0; end
      `SH_ID:    begin opc = OPC_STORE; fmt = FMT_S; f3 = 3'd1; end
      `SW_ID:    begin opc = OPC_STORE; fmt = FMT_S; f3 = 3'd2; end
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_I:   word = {enc.imm_i[11:0], enc.rs1_i, f3, enc.rd_i, opc};
      FMT_SH:  word = {f7, enc.imm_i[4:0], enc.rs1_i, f3, enc.rd_i, opc};
      FMT_R:   word = {f7, enc.rs2_i, enc.rs1_i, f3, enc.rd_i, opc};
      FMT_U:   word = {enc.imm_i[31:12], enc.rd_i, opc};
      FMT_S:   word = {enc.imm_i[11:5], enc.rs2_i, enc.rs1_i, f3, enc.imm_i[4:0], opc};
      default: word = '0;
    endcase
  end

  // Ready comes from the registered count only, so a full FIFO freed by a pop reopens a cycle later.
  assign enc.in_ready_o = ~count_q[1];
  assign accept         = enc.in_valid_i & enc.in_ready_o;
  assign push           = accept & legal;
  assign pop            = out_valid_q & enc.out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = word;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != 2'd0);
    // Head register is loaded from the post-update FIFO so instr_o is a flop, not a mux of entries.
    instr_d     = out_valid_d ? mem_d[rd_ptr_d] : instr_q;
    err_d       = accept & ~legal;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
    end
  end

  assign enc.out_valid_o = out_valid_q;
  assign enc.instr_o     = instr_q;
  assign enc.err_o       = err_q;

`ifdef INSTR_ENC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && !legal && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enc.err_cnt_o = err_cnt_q;
`else
  assign enc.err_cnt_o = '0;
`endif

endmodule
